// File: rtl/nios2_button_pkg.sv
// rtl/nios2_button_pkg.sv - register word addresses and edge-type encodings for nios2_button_pio
package nios2_button_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios2_button_debounce.sv
// rtl/nios2_button_debounce.sv - one-bit two-flop synchroniser plus optional debounce filter
// Filter body present only when NIOS2_BUTTON_DEBOUNCE_EN is defined; otherwise stable_o is the synchronised level.
module nios2_button_debounce
`ifdef NIOS2_BUTTON_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_CYCLES = 50000
)
`endif
(
   input  logic clk,
   input  logic reset_n,
   input  logic in_i,
   output logic stable_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= in_i;
         sync_q <= meta_q;
      end
   end

`ifdef NIOS2_BUTTON_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;

   // The counter only runs while sync disagrees with the accepted level,
   // so it tops out at CNT_LAST and never wraps.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;
`else
   assign stable_o = sync_q;
`endif

endmodule

// File: rtl/nios2_button_pio.sv
// rtl/nios2_button_pio.sv - Avalon-MM button/switch input PIO with edge capture and masked level irq
// Define NIOS2_BUTTON_DEBOUNCE_EN to insert the per-bit debounce filter.
module nios2_button_pio
   import nios2_button_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("nios2_button_pio: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 1");
   end

   if (WIDTH < 32) begin : g_wd_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^writedata[31:WIDTH];
   end

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_dly_q;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [31:0]      rd_q, rd_d;
   logic             wr_en;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios2_button_debounce
`ifdef NIOS2_BUTTON_DEBOUNCE_EN
         #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
         u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_i     (in_port[i]),
            .stable_o (stable[i])
         );
   end

   if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edges = stable & ~stable_dly_q;
   end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edges = ~stable & stable_dly_q;
   end else begin : g_any
      assign edges = stable ^ stable_dly_q;
   end

   // A new edge overrides a same-cycle write-1-to-clear of that bit.
   always_comb begin
      wr_en    = chipselect & ~write_n;
      mask_d   = mask_q;
      clr_bits = '0;
      if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_EDGE) clr_bits = writedata[WIDTH-1:0];
      cap_d = (cap_q & ~clr_bits) | edges;
      case (address)
         ADDR_DATA: rd_d = 32'(stable);
         ADDR_RSVD: rd_d = '0;
         ADDR_MASK: rd_d = 32'(mask_q);
         ADDR_EDGE: rd_d = 32'(cap_q);
         default:   rd_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stable_dly_q <= '0;
         cap_q        <= '0;
         mask_q       <= '0;
         rd_q         <= '0;
      end else begin
         stable_dly_q <= stable;
         cap_q        <= cap_d;
         mask_q       <= mask_d;
         rd_q         <= rd_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios2_button_pio.sv
// tb/tb_nios2_button_pio.sv - scoreboard bench for nios2_button_pio with a cycle-level reference model
module tb_nios2_button_pio;

   localparam int W = 4;
   localparam int D = 4;
`ifdef NIOS2_BUTTON_DEBOUNCE_EN
   localparam int ET  = 0;
   localparam int LAT = 3 + D;
`else
   localparam int ET  = 2;
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [1:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [W-1:0]  in_port = '0;
   logic [31:0]   readdata;
   logic          irq;

   always #5 clk = ~clk;

   nios2_button_pio #(
      .WIDTH           (W),
      .EDGE_TYPE       (ET),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   typedef struct packed {
      logic [31:0] rd;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference state: meaning "value after the most recent clock edge".
   logic [W-1:0] m_meta, m_stab, m_stab_prev, m_cap, m_mask;
   logic [W-1:0] m_sync_hist[$];

   task automatic model_reset();
      m_meta = '0; m_stab = '0; m_stab_prev = '0; m_cap = '0; m_mask = '0;
      m_sync_hist.delete();
      for (int i = 0; i < D; i++) m_sync_hist.push_back('0);
   endtask

   task automatic cycle(input logic rst_v, input logic [W-1:0] in_v, input logic [1:0] a,
                        input logic cs, input logic wn, input logic [31:0] wd);
      exp_t         e;
      logic [W-1:0] new_sync, new_stab, edg, clr;
      e = '0;
      reset_n = rst_v; in_port = in_v; address = a; chipselect = cs; write_n = wn; writedata = wd;
      if (!rst_v) begin
         model_reset();
      end else begin
         new_sync = m_meta;
`ifdef NIOS2_BUTTON_DEBOUNCE_EN
         // Accept a new level once sync has disagreed for the last D cycles.
         new_stab = m_stab;
         for (int b = 0; b < W; b++) begin
            int run;
            run = 0;
            foreach (m_sync_hist[j]) if (m_sync_hist[j][b] != m_stab[b]) run++;
            if (run == D) new_stab[b] = ~m_stab[b];
         end
`else
         new_stab = new_sync;
`endif
         case (ET)
            0:       edg = m_stab & ~m_stab_prev;
            1:       edg = ~m_stab & m_stab_prev;
            default: edg = m_stab ^ m_stab_prev;
         endcase
         clr = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
         case (a)
            2'd0:    e.rd = 32'(m_stab);
            2'd2:    e.rd = 32'(m_mask);
            2'd3:    e.rd = 32'(m_cap);
            default: e.rd = 32'd0;
         endcase
         m_cap = (m_cap & ~clr) | edg;
         if (cs && !wn && a == 2'd2) m_mask = wd[W-1:0];
         m_stab_prev = m_stab;
         m_stab      = new_stab;
         m_meta      = in_v;
         m_sync_hist.push_back(new_sync);
         void'(m_sync_hist.pop_front());
         e.irq = |(m_cap & m_mask);
      end
      @(posedge clk);
      exp_q.push_back(e);
      #2;
   endtask

   task automatic idle(input logic [W-1:0] in_v, input logic [1:0] a, input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, in_v, a, 1'b0, 1'b1, 32'd0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (readdata !== mon_e.rd) begin
               errors++;
               $display("FAIL readdata @%0t: got %h expected %h", $time, readdata, mon_e.rd);
            end
            checks++;
            if (irq !== mon_e.irq) begin
               errors++;
               $display("FAIL irq @%0t: got %b expected %b", $time, irq, mon_e.irq);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] rin;
      model_reset();
      repeat (3) cycle(1'b0, '0, 2'd0, 1'b0, 1'b1, 32'd0);
      for (int a = 0; a < 4; a++) cycle(1'b1, '0, 2'(a), 1'b1, 1'b1, 32'd0);

      // mask 0x5, raise bit 0 and hold
      cycle(1'b1, '0, 2'd2, 1'b1, 1'b0, 32'h5);
      idle(4'h1, 2'd3, LAT + 1);
      idle(4'h1, 2'd0, 2);

      // short pulse on bit 2
      idle(4'h5, 2'd0, 3);
      idle(4'h1, 2'd3, LAT + 3);

      // clear on the same edge a new bit-0 edge lands, then a plain clear
      idle(4'h0, 2'd3, LAT + D + 2);
      for (int i = 1; i <= LAT; i++)
         cycle(1'b1, 4'h1, 2'd3, (i == LAT), (i == LAT) ? 1'b0 : 1'b1, 32'h1);
      cycle(1'b1, 4'h1, 2'd3, 1'b1, 1'b0, 32'h1);
      idle(4'h1, 2'd3, 2);

      // capture with mask 0, then unmask
      cycle(1'b1, 4'h1, 2'd2, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 4'h1, 2'd3, 1'b1, 1'b0, 32'hF);
      idle(4'h3, 2'd3, LAT + 2);
      cycle(1'b1, 4'h3, 2'd2, 1'b1, 1'b0, 32'h2);
      idle(4'h3, 2'd3, 2);

      // bit 3 high, clear, low
      idle(4'hB, 2'd3, LAT + 2);
      cycle(1'b1, 4'hB, 2'd3, 1'b1, 1'b0, 32'hF);
      idle(4'h3, 2'd3, LAT + 2);

      // reset mid-operation while an edge is in flight
      idle(4'hC, 2'd3, 2);
      cycle(1'b0, 4'hC, 2'd3, 1'b0, 1'b1, 32'd0);
      idle(4'hC, 2'd3, LAT + 3);

      // randomized phase
      rin = '0;
      for (int seg = 0; seg < 150; seg++) begin
         int hold;
         rin  = W'($urandom);
         hold = $urandom_range(1, 2 * D + 3);
         for (int c = 0; c < hold; c++) begin
            logic wr;
            wr = ($urandom_range(0, 7) == 0);
            cycle(($urandom_range(0, 299) != 0), rin, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), ~wr, $urandom);
         end
      end
      idle(rin, 2'd3, 2);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
